// File: rtl/sba_pkg.sv
// rtl/sba_pkg.sv - shared types and access-size helpers for the system bus access path
package sba_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GNT_WAIT,
    MEM_ACCESS,
    MEM_WAIT,
    RESP
  } sba_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // True when the low address bits are zero for a naturally aligned access of 2**size bytes.
  function automatic logic is_aligned(input logic [2:0] addr_lsbs, input logic [1:0] size);
    logic [3:0] mask;
    mask = (4'd1 << size) - 4'd1;
    return (addr_lsbs & mask[2:0]) == 3'd0;
  endfunction

  function automatic logic size_legal(input logic [1:0] size, input int data_width);
    return int'(size) <= $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sba_mem_responder.sv
// rtl/sba_mem_responder.sv - single-outstanding req/gnt/valid responder in front of a fixed-latency SRAM port
import sba_pkg::*;

module sba_mem_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1,
  parameter int GNT_DELAY   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [1:0]                size_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_WIDTH);
  localparam int CNT_MAX  = (MEM_LATENCY > GNT_DELAY) ? MEM_LATENCY : GNT_DELAY;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);
  // Counters are loaded one short so the terminal action happens on the cycle they read zero.
  localparam logic [CNT_W-1:0] GNT_LOAD = CNT_W'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  sba_state_e state_q, state_d;
  logic [CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic req_err, req_skip_mem, rsp_err, rdata_capture;

  assign req_err      = !size_legal(size_i, DATA_WIDTH) || !is_aligned(addr_i[2:0], size_i);
  assign req_skip_mem = we_i && (be_i == '0);
  assign rsp_err      = !size_legal(size_q, DATA_WIDTH) || !is_aligned(addr_q[2:0], size_q);

  always_comb begin
    state_d       = state_q;
    gnt_cnt_d     = gnt_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    gnt_o         = 1'b0;
    rdata_capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (GNT_DELAY == 0) begin
            gnt_o = 1'b1;
          end else begin
            state_d   = GNT_WAIT;
            gnt_cnt_d = GNT_LOAD;
          end
        end
      end
      GNT_WAIT: begin
        if (!req_i) begin
          state_d = IDLE;
        end else if (gnt_cnt_q == '0) begin
          gnt_o = 1'b1;
        end else begin
          gnt_cnt_d = gnt_cnt_q - 1'b1;
        end
      end
      MEM_ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d   = MEM_WAIT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      MEM_WAIT: begin
        if (lat_cnt_q == '0) begin
          rdata_capture = 1'b1;
          state_d       = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Grant is combinational with req_i, so it must also be forced low while reset is held.
    if (!rst_ni) begin
      gnt_o = 1'b0;
    end
    if (gnt_o) begin
      state_d = (req_err || req_skip_mem) ? RESP : MEM_ACCESS;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_cnt_q <= '0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_cnt_q <= gnt_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      if (gnt_o) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
        size_q  <= size_i;
      end
      if (rdata_capture) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  assign valid_o     = (state_q == RESP);
  assign err_o       = valid_o && rsp_err;
  assign rdata_o     = rdata_q;

  assign mem_req_o   = (state_q == MEM_ACCESS);
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_addr_o  = mem_req_o ? (addr_q & WORD_MASK) : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
  assign mem_be_o    = mem_req_o ? be_q : '0;

endmodule
